// File: rtl/vertex_rs_pp.sv
// Ping-pong reservation station: assembles sos/eos framed feature vectors into two
// banks of per-node entries and issues one bank at a time to the vertex PE array.
module vertex_rs_pp #(
  parameter int NUM_ENTRIES = 4,
  parameter int FV_MAX      = 16,
  parameter int ELEM_W      = 16,
  parameter int CHUNK       = 2,
  parameter int OUT_ELEMS   = 2,
  parameter int NODE_ID_W   = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_sos,
  input  logic                                  in_eos,
  input  logic [NODE_ID_W-1:0]                  in_node_id,
  input  logic [CHUNK*ELEM_W-1:0]               in_data,
  input  logic                                  flush,
  input  logic [$clog2(FV_MAX)-1:0]             start_idx,
  input  logic                                  pe_release,
  output logic                                  out_fire,
  output logic [NUM_ENTRIES-1:0]                out_valid_mask,
  output logic [NUM_ENTRIES*NODE_ID_W-1:0]      out_node_id,
  output logic [NUM_ENTRIES*OUT_ELEMS*ELEM_W-1:0] out_data,
  output logic                                  overflow,
  output logic                                  rs_empty
);
  localparam int IDX_W  = $clog2(FV_MAX);
  localparam int ENT_W  = $clog2(NUM_ENTRIES);
  localparam int CNT_W  = ENT_W + 1;
  localparam int BEATS  = FV_MAX / CHUNK;
  localparam int BEAT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {FREE = 2'd0, FILLING = 2'd1, READY = 2'd2, ISSUED = 2'd3} bank_st_e;

  bank_st_e                bank_st_r  [2];
  bank_st_e                bank_nxt_s [2];
  logic [CNT_W-1:0]        cnt_r      [2];
  logic                    fill_ptr_r, issue_ptr_r, out_bank_r;
  logic                    open_r, flush_pend_r, overflow_r, out_fire_r;
  logic [BEAT_W-1:0]       beat_r;
  logic [ELEM_W-1:0]       mem_r [2][NUM_ENTRIES][FV_MAX];
  logic [NODE_ID_W-1:0]    nid_r [2][NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  mask_r;
  logic [NUM_ENTRIES*NODE_ID_W-1:0] nid_out_r;
  logic [NUM_ENTRIES*OUT_ELEMS*ELEM_W-1:0] data_r;

  logic accept_s, fill_free_s, start_s, force_s, full_f_s, new_s, cont_s, drop_s, wr_s;
  logic close_s, open_nxt_s, filling_s, go_ready_s, release_s, fire_s, sel_s;
  logic [CNT_W-1:0]  cur_cnt_s, cnt_f_s, cnt_nxt_s;
  logic [BEAT_W-1:0] beat_nxt_s;
  logic [ENT_W-1:0]  wr_ent_s;
  logic [IDX_W-1:0]  wr_base_s;
  logic [IDX_W:0]    win_idx_s [OUT_ELEMS];
  logic [NUM_ENTRIES-1:0] mask_s;
  logic [NUM_ENTRIES*NODE_ID_W-1:0] nid_pack_s;
  logic [NUM_ENTRIES*OUT_ELEMS*ELEM_W-1:0] win_s;

  assign in_ready = (bank_st_r[fill_ptr_r] == FREE) || (bank_st_r[fill_ptr_r] == FILLING);
  assign rs_empty = (bank_st_r[0] == FREE) && (bank_st_r[1] == FREE) && !open_r;
  assign out_fire       = out_fire_r;
  assign out_valid_mask = mask_r;
  assign out_node_id    = nid_out_r;
  assign out_data       = data_r;
  assign overflow       = overflow_r;

  // Fill-side decode: entry open/close, beat placement, bank completion.
  always_comb begin
    accept_s    = in_valid && in_ready;
    fill_free_s = (bank_st_r[fill_ptr_r] == FREE);
    cur_cnt_s   = fill_free_s ? {CNT_W{1'b0}} : cnt_r[fill_ptr_r];
    start_s     = accept_s && in_sos;
    force_s     = start_s && open_r;
    cnt_f_s     = cur_cnt_s + CNT_W'(force_s);
    // A force-close that completes the bank leaves no room for the new entry.
    full_f_s    = force_s && (cnt_f_s == CNT_W'(NUM_ENTRIES));
    new_s       = start_s && !full_f_s;
    cont_s      = accept_s && !in_sos && open_r;
    drop_s      = cont_s && (beat_r >= BEAT_W'(BEATS));
    wr_s        = new_s || (cont_s && !drop_s);
    wr_ent_s    = cnt_f_s[ENT_W-1:0];
    wr_base_s   = new_s ? {IDX_W{1'b0}} : IDX_W'(beat_r) * IDX_W'(CHUNK);
    close_s     = (new_s || cont_s) && in_eos;
    cnt_nxt_s   = cnt_f_s + CNT_W'(close_s);
    if (new_s) begin
      open_nxt_s = !in_eos;
    end else if (close_s || full_f_s) begin
      open_nxt_s = 1'b0;
    end else begin
      open_nxt_s = open_r;
    end
    if (new_s) begin
      beat_nxt_s = BEAT_W'(1);
    end else if (cont_s && !drop_s) begin
      beat_nxt_s = beat_r + BEAT_W'(1);
    end else begin
      beat_nxt_s = beat_r;
    end
    filling_s  = (bank_st_r[fill_ptr_r] == FILLING) || (fill_free_s && new_s);
    go_ready_s = filling_s && ((cnt_nxt_s == CNT_W'(NUM_ENTRIES)) ||
                 ((flush || flush_pend_r) && (cnt_nxt_s != {CNT_W{1'b0}}) && !open_nxt_s));
    release_s  = pe_release && (bank_st_r[out_bank_r] == ISSUED);
    fire_s     = (bank_st_r[issue_ptr_r] == READY) &&
                 (release_s || (bank_st_r[out_bank_r] != ISSUED));
  end

  // Bank next-state logic.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nxt_s[b] = bank_st_r[b];
      case (bank_st_r[b])
        FREE: begin
          if ((fill_ptr_r == 1'(b)) && new_s) bank_nxt_s[b] = go_ready_s ? READY : FILLING;
          else bank_nxt_s[b] = FREE;
        end
        FILLING: begin
          if ((fill_ptr_r == 1'(b)) && go_ready_s) bank_nxt_s[b] = READY;
          else bank_nxt_s[b] = FILLING;
        end
        READY: begin
          if (fire_s && (issue_ptr_r == 1'(b))) bank_nxt_s[b] = ISSUED;
          else bank_nxt_s[b] = READY;
        end
        ISSUED: begin
          if (pe_release) bank_nxt_s[b] = FREE;
          else bank_nxt_s[b] = ISSUED;
        end
        default: bank_nxt_s[b] = FREE;
      endcase
    end
  end

  // Bank state and fill bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_st_r[0] <= FREE;
      bank_st_r[1] <= FREE;
      cnt_r[0]     <= {CNT_W{1'b0}};
      cnt_r[1]     <= {CNT_W{1'b0}};
      fill_ptr_r   <= 1'b0;
      open_r       <= 1'b0;
      beat_r       <= {BEAT_W{1'b0}};
      flush_pend_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_nxt_s[0];
      bank_st_r[1] <= bank_nxt_s[1];
      if (accept_s) cnt_r[fill_ptr_r] <= cnt_nxt_s;
      open_r       <= open_nxt_s;
      beat_r       <= beat_nxt_s;
      flush_pend_r <= go_ready_s ? 1'b0 : (flush_pend_r || (flush && filling_s && open_nxt_s));
      overflow_r   <= overflow_r || force_s || drop_s;
      if (go_ready_s) fill_ptr_r <= ~fill_ptr_r;
    end
  end

  // Entry storage: cleared when a bank starts filling, then written beat by beat.
  always_ff @(posedge clk) begin
    if (!reset && fill_free_s && new_s) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        nid_r[fill_ptr_r][e] <= {NODE_ID_W{1'b0}};
        for (int i = 0; i < FV_MAX; i++) mem_r[fill_ptr_r][e][i] <= {ELEM_W{1'b0}};
      end
    end
    if (!reset && wr_s) begin
      for (int k = 0; k < CHUNK; k++)
        mem_r[fill_ptr_r][wr_ent_s][wr_base_s + IDX_W'(k)] <= in_data[k*ELEM_W +: ELEM_W];
      if (new_s) nid_r[fill_ptr_r][wr_ent_s] <= in_node_id;
    end
  end

  // Output window, valid mask and node-id packing for the bank being presented.
  always_comb begin
    sel_s = fire_s ? issue_ptr_r : out_bank_r;
    for (int k = 0; k < OUT_ELEMS; k++) win_idx_s[k] = {1'b0, start_idx} + (IDX_W+1)'(k);
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      mask_s[e] = (CNT_W'(e) < cnt_r[issue_ptr_r]);
      nid_pack_s[e*NODE_ID_W +: NODE_ID_W] = nid_r[issue_ptr_r][e];
      for (int k = 0; k < OUT_ELEMS; k++) begin
        if (win_idx_s[k] < (IDX_W+1)'(FV_MAX))
          win_s[(e*OUT_ELEMS+k)*ELEM_W +: ELEM_W] = mem_r[sel_s][e][win_idx_s[k][IDX_W-1:0]];
        else
          win_s[(e*OUT_ELEMS+k)*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
      end
    end
  end

  // Issue registers: fire pulse, captured bank view, window tracking start_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_fire_r  <= 1'b0;
      issue_ptr_r <= 1'b0;
      out_bank_r  <= 1'b0;
      mask_r      <= {NUM_ENTRIES{1'b0}};
      nid_out_r   <= {(NUM_ENTRIES*NODE_ID_W){1'b0}};
      data_r      <= {(NUM_ENTRIES*OUT_ELEMS*ELEM_W){1'b0}};
    end else begin
      out_fire_r <= fire_s;
      if (fire_s) begin
        issue_ptr_r <= ~issue_ptr_r;
        out_bank_r  <= issue_ptr_r;
        mask_r      <= mask_s;
        nid_out_r   <= nid_pack_s;
      end
      if (fire_s || (bank_st_r[out_bank_r] == ISSUED)) data_r <= win_s;
    end
  end
endmodule

// File: tb/tb_vertex_rs_pp.sv
// Directed self-checking bench for vertex_rs_pp with hand-computed expectations.
module tb_vertex_rs_pp;
  logic         clk = 1'b0;
  logic         reset, in_valid, in_sos, in_eos, flush, pe_release;
  logic [9:0]   in_node_id;
  logic [31:0]  in_data;
  logic [3:0]   start_idx;
  logic         in_ready, out_fire, overflow, rs_empty;
  logic [3:0]   out_valid_mask;
  logic [39:0]  out_node_id;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   sidx;
    logic [127:0] exp_data;
  } win_vec_t;
  win_vec_t tbl [5];

  vertex_rs_pp dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sos(in_sos), .in_eos(in_eos), .in_node_id(in_node_id), .in_data(in_data),
    .flush(flush), .start_idx(start_idx), .pe_release(pe_release),
    .out_fire(out_fire), .out_valid_mask(out_valid_mask), .out_node_id(out_node_id),
    .out_data(out_data), .overflow(overflow), .rs_empty(rs_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sos, input logic eos, input logic [9:0] id, input logic [31:0] d);
    in_valid = 1'b1; in_sos = sos; in_eos = eos; in_node_id = id; in_data = d;
    tick();
    in_valid = 1'b0; in_sos = 1'b0; in_eos = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic pulse_release();
    pe_release = 1'b1; tick(); pe_release = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'd0,  128'h0301_0300_0201_0200_0101_0100_0001_0000};
    tbl[1] = '{4'd9,  128'h030a_0309_020a_0209_010a_0109_000a_0009};
    tbl[2] = '{4'd14, 128'h030f_030e_020f_020e_010f_010e_000f_000e};
    tbl[3] = '{4'd15, 128'h0000_030f_0000_020f_0000_010f_0000_000f};
    tbl[4] = '{4'd2,  128'h0303_0302_0203_0202_0103_0102_0003_0002};

    reset = 1'b1; in_valid = 1'b0; in_sos = 1'b0; in_eos = 1'b0; flush = 1'b0;
    pe_release = 1'b0; in_node_id = 10'd0; in_data = 32'd0; start_idx = 4'd2;
    tick(); tick();
    chk("rst_fire",     128'(out_fire),       128'(1'b0));
    chk("rst_mask",     128'(out_valid_mask), 128'(4'b0000));
    chk("rst_nid",      128'(out_node_id),    128'(40'd0));
    chk("rst_data",     out_data,             128'd0);
    chk("rst_ovf",      128'(overflow),       128'(1'b0));
    chk("rst_empty",    128'(rs_empty),       128'(1'b1));
    chk("rst_ready",    128'(in_ready),       128'(1'b1));
    reset = 1'b0;

    // Four full 8-beat frames; element i of entry n = n*256 + i.
    for (int n = 0; n < 4; n++)
      for (int b = 0; b < 8; b++)
        beat(b == 0, b == 7, 10'(5 + n), {16'(n*256 + 2*b + 1), 16'(n*256 + 2*b)});
    chk("full_fire_early", 128'(out_fire), 128'(1'b0));
    chk("full_ready_b1",   128'(in_ready), 128'(1'b1));
    tick();
    chk("full_fire", 128'(out_fire),       128'(1'b1));
    chk("full_mask", 128'(out_valid_mask), 128'(4'b1111));
    chk("full_nid",  128'(out_node_id),    128'({10'd8, 10'd7, 10'd6, 10'd5}));
    chk("full_data", out_data, 128'h0303_0302_0203_0202_0103_0102_0003_0002);

    for (int i = 0; i < 5; i++) begin
      start_idx = tbl[i].sidx;
      tick();
      chk("win_data", out_data, tbl[i].exp_data);
      chk("win_fire", 128'(out_fire), 128'(1'b0));
      chk("win_mask", 128'(out_valid_mask), 128'(4'b1111));
    end

    // Fill bank1 while bank0 is held; input must stall.
    start_idx = 4'd0;
    for (int n = 0; n < 4; n++) beat(1'b1, 1'b1, 10'(9 + n), {16'(16'h00B0 + n), 16'(16'h00A0 + n)});
    chk("pp_stall_ready", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b1; in_sos = 1'b1; in_eos = 1'b1; in_node_id = 10'd99;
    tick(); tick();
    in_valid = 1'b0; in_sos = 1'b0; in_eos = 1'b0;
    chk("pp_stall_fire",  128'(out_fire), 128'(1'b0));
    chk("pp_hold_nid",    128'(out_node_id), 128'({10'd8, 10'd7, 10'd6, 10'd5}));
    pulse_release();
    chk("pp_fire",  128'(out_fire),    128'(1'b1));
    chk("pp_ready", 128'(in_ready),    128'(1'b1));
    chk("pp_nid",   128'(out_node_id), 128'({10'd12, 10'd11, 10'd10, 10'd9}));
    chk("pp_data",  out_data, 128'h00B3_00A3_00B2_00A2_00B1_00A1_00B0_00A0);
    pulse_release();

    // Two nodes then flush.
    for (int n = 0; n < 2; n++)
      for (int b = 0; b < 2; b++)
        beat(b == 0, b == 1, 10'(20 + n), {16'(16'hC000 + b), 16'(16'hD000 + b)});
    pulse_flush();
    chk("fl_fire_early", 128'(out_fire), 128'(1'b0));
    tick();
    chk("fl_fire", 128'(out_fire),       128'(1'b1));
    chk("fl_mask", 128'(out_valid_mask), 128'(4'b0011));
    chk("fl_nid",  128'(out_node_id),    128'({10'd0, 10'd0, 10'd21, 10'd20}));
    pulse_release();

    // Flush while a frame is open waits for that frame's eos.
    beat(1'b1, 1'b1, 10'd30, 32'h0000_0030);
    beat(1'b1, 1'b0, 10'd31, 32'h0000_0031);
    pulse_flush();
    chk("flm_empty", 128'(rs_empty), 128'(1'b0));
    tick(); tick();
    chk("flm_no_fire", 128'(out_fire), 128'(1'b0));
    beat(1'b0, 1'b1, 10'd0, 32'h0000_0032);
    tick();
    chk("flm_fire", 128'(out_fire),       128'(1'b1));
    chk("flm_mask", 128'(out_valid_mask), 128'(4'b0011));
    chk("flm_nid",  128'(out_node_id),    128'({10'd0, 10'd0, 10'd31, 10'd30}));
    pulse_release();

    // Single-beat frame reuses a bank that previously held longer frames.
    beat(1'b1, 1'b1, 10'd3, 32'h1234_5678);
    chk("sb_ovf", 128'(overflow), 128'(1'b0));
    pulse_flush();
    tick();
    chk("sb_fire", 128'(out_fire),       128'(1'b1));
    chk("sb_mask", 128'(out_valid_mask), 128'(4'b0001));
    chk("sb_nid",  128'(out_node_id),    128'({10'd0, 10'd0, 10'd0, 10'd3}));
    chk("sb_data", out_data, 128'h1234_5678);
    start_idx = 4'd2;
    tick();
    chk("sb_cleared", out_data, 128'd0);
    pulse_release();

    // Nine beats on one frame: the ninth is dropped.
    for (int b = 0; b < 8; b++) beat(b == 0, 1'b0, 10'd40, {16'(2*b + 1), 16'(2*b)});
    chk("ov_8beats", 128'(overflow), 128'(1'b0));
    beat(1'b0, 1'b1, 10'd0, 32'hDEAD_BEEF);
    chk("ov_9th", 128'(overflow), 128'(1'b1));
    chk("ov_empty", 128'(rs_empty), 128'(1'b0));
    pulse_flush();
    start_idx = 4'd14;
    tick();
    chk("ov_fire", 128'(out_fire), 128'(1'b1));
    chk("ov_data", out_data, 128'h000F_000E);
    tick();
    chk("ov_sticky", 128'(overflow), 128'(1'b1));
    pulse_release();

    // Reset while bank0 is issued and bank1 is mid-fill.
    beat(1'b1, 1'b1, 10'd45, 32'h0000_0045);
    pulse_flush();
    tick();
    chk("rm_fire", 128'(out_fire), 128'(1'b1));
    beat(1'b1, 1'b0, 10'd50, 32'h0000_0050);
    reset = 1'b1; tick(); 
    chk("rm_fire0",  128'(out_fire),       128'(1'b0));
    chk("rm_mask0",  128'(out_valid_mask), 128'(4'b0000));
    chk("rm_nid0",   128'(out_node_id),    128'(40'd0));
    chk("rm_data0",  out_data,             128'd0);
    chk("rm_ovf0",   128'(overflow),       128'(1'b0));
    chk("rm_empty",  128'(rs_empty),       128'(1'b1));
    chk("rm_ready",  128'(in_ready),       128'(1'b1));
    reset = 1'b0;
    start_idx = 4'd0;
    beat(1'b1, 1'b1, 10'd60, 32'h0000_0060);
    pulse_flush();
    tick();
    chk("rm_new_fire", 128'(out_fire),       128'(1'b1));
    chk("rm_new_mask", 128'(out_valid_mask), 128'(4'b0001));
    chk("rm_new_nid",  128'(out_node_id),    128'({10'd0, 10'd0, 10'd0, 10'd60}));
    chk("rm_new_data", out_data,             128'h60);
    pulse_release();

    // Second sos without eos force-closes the open entry.
    beat(1'b1, 1'b0, 10'd70, 32'h0007_0007);
    chk("fc_ovf_before", 128'(overflow), 128'(1'b0));
    beat(1'b1, 1'b1, 10'd71, 32'h0007_1007);
    chk("fc_ovf", 128'(overflow), 128'(1'b1));
    pulse_flush();
    tick();
    chk("fc_fire", 128'(out_fire),       128'(1'b1));
    chk("fc_mask", 128'(out_valid_mask), 128'(4'b0011));
    chk("fc_nid",  128'(out_node_id),    128'({10'd0, 10'd0, 10'd71, 10'd70}));
    chk("fc_data", out_data,             128'h0007_1007_0007_0007);
    pulse_release();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vertex_rs_pp.md
Name: vertex_rs_pp

Overview:
Parametrised ping-pong reservation station between the bank read path and the vertex PE array. It assembles framed feature-vector streams (sos/eos) into NUM_ENTRIES per-node entries per bank. It issues a full bank, or a flushed partial bank, to the PEs with a one-cycle fire pulse, and holds it until the PEs release it. The second bank keeps filling meanwhile, so a full bank never stalls the input unless both banks are occupied.

Parameters:
NUM_ENTRIES, 4, entries per bank (= PE count); power of 2, >=2
FV_MAX, 16, max feature elements per node; multiple of CHUNK
ELEM_W, 16, bits per feature element
CHUNK, 2, elements per input beat
OUT_ELEMS, 2, elements per entry presented to each PE
NODE_ID_W, 10, node id width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  RS can accept a beat this cycle
in_sos  in  1  first beat of a node's vector
in_eos  in  1  last beat of a node's vector; may coincide with in_sos
in_node_id  in  NODE_ID_W  node id, sampled on the sos beat
in_data  in  CHUNK*ELEM_W  element chunk; element 0 in the LSBs
flush  in  1  close the current bank early if it holds >=1 closed entry
start_idx  in  clog2(FV_MAX)  first element of the output window
pe_release  in  1  PEs finished with the issued bank
out_fire  out  1  one-cycle issue pulse
out_valid_mask  out  NUM_ENTRIES  entries populated in the issued bank
out_node_id  out  NUM_ENTRIES*NODE_ID_W  per-entry node id
out_data  out  NUM_ENTRIES*OUT_ELEMS*ELEM_W  per-entry window data
overflow  out  1  sticky: beat beyond FV_MAX dropped, or sos without prior eos
rs_empty  out  1  both banks FREE and no entry open

Behaviour:
- A beat is accepted when in_valid && in_ready. in_ready = (fill bank is FREE or FILLING). It is combinational from the bank state only.
- Bank states: FREE, FILLING, READY, ISSUED.
  - FREE->FILLING on the first accepted sos.
  - FILLING->READY when the NUM_ENTRIES-th entry closes on eos, or on flush with >=1 closed entry and no entry open. If an entry is open, the flush is held pending until its eos.
  - READY->ISSUED on the cycle out_fire is asserted.
  - ISSUED->FREE on pe_release.
- Fill pointer alternates banks. After a bank goes READY, filling moves to the other bank if it is FREE; otherwise in_ready=0.
- Entry writes:
  - On the sos beat, beat counter b=0, node id captured, chunk written at elements [0,CHUNK).
  - Each further beat writes elements [b*CHUNK, b*CHUNK+CHUNK).
  - Unwritten elements read 0; entries are cleared when the bank enters FILLING.
  - A beat with b*CHUNK >= FV_MAX is dropped and sets overflow.
  - sos while an entry is open: the open entry is force-closed, a new entry starts, and overflow is set.
  - A beat without sos and no entry open is dropped silently.
- Issue: out_fire pulses for exactly one cycle when a bank is READY and no bank is ISSUED. out_fire asserts the cycle after the READY transition at the earliest. If both banks are READY, the older bank issues first.
- Outputs:
  - out_valid_mask, out_node_id, and out_data of the ISSUED bank are registered. They are stable from the out_fire cycle until pe_release.
  - out_data[e] = elements [start_idx, start_idx+OUT_ELEMS) of entry e. Indices >= FV_MAX read 0.
  - start_idx changes are reflected 1 cycle later.
- pe_release with no ISSUED bank is ignored. pe_release in the same cycle as a READY bank: the bank frees this cycle; the next bank fires the following cycle.
- Reset values: out_fire=0, out_valid_mask=0, out_node_id=0, out_data=0, overflow=0, rs_empty=1, in_ready=1. Both banks are FREE and the fill pointer is at bank 0. Reset mid-frame discards all content.

Test Plan:
- 4 nodes (ids 5,6,7,8) × 8 beats, data = beat index -> out_fire 1 cycle after the 4th eos. out_valid_mask=4'b1111, out_node_id={8,7,6,5}. With start_idx=2, each entry's out_data = elements {2,3} = {1,1}.
- Fill bank0 and bank1 with pe_release held low -> in_ready drops after bank1 READY, and beats are not accepted. pe_release -> bank1 fires 1 cycle later; in_ready=1.
- 2 nodes, then flush -> fire with out_valid_mask=4'b0011. flush asserted mid-frame -> fire only after that frame's eos.
- Single-beat frame (sos&&eos) with node id 3 -> entry 0 elements {d0,d1}, rest 0; overflow=0.
- 9 beats on one frame (FV_MAX=16, CHUNK=2) -> 9th beat dropped, overflow=1 sticky; a second sos without eos also sets overflow.
- reset asserted mid-fill of bank1 while bank0 is ISSUED -> next cycle all outputs 0, rs_empty=1, a new frame fills bank 0.
